// File: rtl/rep_code_pkg.sv
// Shared types and constants for the repetition-code transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default DATA_W/REP, and a helper that returns
// the number of channel symbols produced per accepted word. Parity builds
// (REP_CODE_PARITY_EN defined) add one extra bit period per word.
package rep_code_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      PAR  = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int REP_DEF    = 4;

   function automatic int syms_per_word(input int data_w, input int rep);
`ifdef REP_CODE_PARITY_EN
      return (data_w + 1) * rep;
`else
      return data_w * rep;
`endif
   endfunction

endpackage

// File: rtl/rep_code_repeater.sv
// Copy counter: counts handshakes of the current bit and flags its last copy.
// Latency: last_copy is combinational from the registered count.
// Backpressure: count only advances on step, so it holds while stalled.
//
// Ports: clk, rst_n (sync, active-low), step (symbol handshake),
//        clear (restart at copy 0), last_copy (current copy is REP-1).
module rep_code_repeater
   import rep_code_pkg::*;
#(
   parameter int REP = REP_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic step,
   input  logic clear,
   output logic last_copy
);

   // A single-copy code still needs a 1-bit counter so the compare is legal.
   localparam int CW = (REP > 1) ? $clog2(REP) : 1;
   localparam logic [CW-1:0] REP_LAST = CW'(REP - 1);

   logic [CW-1:0] rep_cnt_q;

   assign last_copy = (rep_cnt_q == REP_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rep_cnt_q <= '0;
      end else if (clear) begin
         rep_cnt_q <= '0;
      end else if (step) begin
         // Wraps only by explicit clear on the final copy, never by overflow.
         if (last_copy) rep_cnt_q <= '0;
         else           rep_cnt_q <= rep_cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/rep_code_tx.sv
// Repetition-code transmitter: serialises a word LSB-first, each bit REP times.
// Latency: word accepted at edge N -> first symbol valid in cycle N+1.
// Backpressure: tx_ready low freezes tx_bit, shift register and counters.
//
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data word input;
//        tx_valid/tx_ready/tx_bit symbol output; busy (word in flight);
//        done (one-cycle pulse after the final symbol handshake).
// Option: REP_CODE_PARITY_EN appends an even-parity bit (REP copies) after
//         the MSB; parity is taken from the word at capture.
module rep_code_tx
   import rep_code_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REP    = REP_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_bit,
   output logic              busy,
   output logic              done
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   state_t            state_q, state_n;
   logic [DATA_W-1:0] shreg_q, shreg_n;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_n;
   logic              tx_valid_q, tx_bit_q, busy_q, done_q, in_ready_q;
   logic              tx_bit_n, done_n;
   logic              accept, hs, last_copy;
`ifdef REP_CODE_PARITY_EN
   logic              par_q, par_n;
`endif

   // in_ready_q is high only while IDLE, and low during reset.
   assign accept = in_valid && in_ready_q;
   assign hs     = tx_valid_q && tx_ready;

   rep_code_repeater #(
      .REP (REP)
   ) u_repeater (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (hs),
      .clear     (accept),
      .last_copy (last_copy)
   );

   always_comb begin
      state_n   = state_q;
      shreg_n   = shreg_q;
      bit_cnt_n = bit_cnt_q;
      done_n    = 1'b0;
`ifdef REP_CODE_PARITY_EN
      par_n     = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_n   = in_data;
               bit_cnt_n = '0;
               state_n   = SEND;
`ifdef REP_CODE_PARITY_EN
               par_n     = ^in_data;
`endif
            end
         end
         SEND: begin
            if (hs && last_copy) begin
               shreg_n   = shreg_q >> 1;
               bit_cnt_n = bit_cnt_q + BW'(1);
               if (bit_cnt_q == BIT_LAST) begin
`ifdef REP_CODE_PARITY_EN
                  state_n = PAR;
`else
                  state_n = IDLE;
                  done_n  = 1'b1;
`endif
               end
            end
         end
`ifdef REP_CODE_PARITY_EN
         PAR: begin
            if (hs && last_copy) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
`endif
         default: state_n = IDLE;
      endcase

      // Outputs are registered, so they are derived from the next state.
      tx_bit_n = 1'b0;
      if (state_n == SEND) tx_bit_n = shreg_n[0];
`ifdef REP_CODE_PARITY_EN
      else if (state_n == PAR) tx_bit_n = par_n;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_bit_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
`ifdef REP_CODE_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_n;
         shreg_q    <= shreg_n;
         bit_cnt_q  <= bit_cnt_n;
         tx_valid_q <= (state_n != IDLE);
         tx_bit_q   <= tx_bit_n;
         busy_q     <= (state_n != IDLE);
         done_q     <= done_n;
         in_ready_q <= (state_n == IDLE);
`ifdef REP_CODE_PARITY_EN
         par_q      <= par_n;
`endif
      end
   end

   assign in_ready = in_ready_q;
   assign tx_valid = tx_valid_q;
   assign tx_bit   = tx_bit_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rep_code_tx.sv
// Testbench for rep_code_tx with DATA_W=8, REP=4.
// Table vectors with fixed tx_ready patterns, hand-written corner sequences,
// and random words under random backpressure against a reference model.
module tb_rep_code_tx;

   localparam int DW  = 8;
   localparam int REP = 4;
`ifdef REP_CODE_PARITY_EN
   localparam int NSYM = (DW + 1) * REP;
`else
   localparam int NSYM = DW * REP;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          tx_bit;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   rep_code_tx #(
      .DATA_W (DW),
      .REP    (REP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_bit   (tx_bit),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [DW-1:0] data;
      int            mode;       // 0: ready high, 1: 1,0,0,1 pattern, 2: random
      logic [31:0]   exp_stream; // bit k = symbol k of the data part
      logic          exp_par;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Symbol k carries data bit k/REP; trailing copies carry even parity.
   function automatic logic [63:0] model(input logic [DW-1:0] w);
      logic [63:0] s;
      int b;
      s = '0;
      for (int k = 0; k < NSYM; k++) begin
         b = k / REP;
         if (b < DW) s[k] = w[b];
         else        s[k] = (($countones(w) % 2) == 1);
      end
      return s;
   endfunction

   function automatic logic ready_bit(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
      return 1'($urandom_range(0, 1));
   endfunction

   // Caller is at a sample point with the block idle.
   task automatic do_word(input logic [DW-1:0] w, input int mode, output logic [63:0] got);
      int   hs_cnt;
      int   cyc;
      int   early;
      bit   stalled;
      logic held;
      check("idle_in_ready", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = w;
      tx_ready = 1'b1;
      step();
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      check("first_sym_valid", 64'(tx_valid), 64'(1));
      got = '0; hs_cnt = 0; cyc = 0; early = 0; stalled = 0; held = 1'b0;
      while (hs_cnt < NSYM && cyc < 1000) begin
         if (stalled) check("stall_hold", 64'({tx_valid, tx_bit}), 64'({1'b1, held}));
         if (done) early++;
         tx_ready = ready_bit(mode, cyc);
         if (tx_valid && tx_ready) begin
            got[hs_cnt] = tx_bit;
            hs_cnt++;
            stalled = 1'b0;
         end else begin
            stalled = tx_valid;
            held    = tx_bit;
         end
         step();
         cyc++;
      end
      tx_ready = 1'b1;
      check("sym_count", 64'(hs_cnt), 64'(NSYM));
      check("early_done", 64'(early), 64'(0));
      if (mode == 0) check("unstalled_cycles", 64'(cyc), 64'(NSYM));
      check("done_pulse", 64'(done), 64'(1));
      check("done_in_ready", 64'(in_ready), 64'(1));
      check("done_tx_valid", 64'(tx_valid), 64'(0));
      step();
      check("done_one_cycle", 64'(done), 64'(0));
   endtask

   initial begin
      logic [63:0] got;
      logic [63:0] exp;
      int          hs_cnt;
      int          cyc;
      int          bad_rdy;
      logic [DW-1:0] w;

      vecs[0] = '{8'hA5, 0, 32'hF0F00F0F, 1'b0};
      vecs[1] = '{8'h3C, 1, 32'h00FFFF00, 1'b0};
      vecs[2] = '{8'h07, 0, 32'h00000FFF, 1'b1};
      vecs[3] = '{8'h01, 1, 32'h0000000F, 1'b1};
      vecs[4] = '{8'h80, 0, 32'hF0000000, 1'b1};
      vecs[5] = '{8'h00, 1, 32'h00000000, 1'b0};
      vecs[6] = '{8'hFF, 2, 32'hFFFFFFFF, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tx_ready = 1'b0;
      repeat (3) step();
      check("rst_tx_valid", 64'(tx_valid), 64'(0));
      check("rst_tx_bit", 64'(tx_bit), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      rst_n = 1'b1;
      step();
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      check("post_rst_tx_valid", 64'(tx_valid), 64'(0));

      // Table vectors
      for (int i = 0; i < 7; i++) begin
         do_word(vecs[i].data, vecs[i].mode, got);
         exp = 64'(vecs[i].exp_stream);
`ifdef REP_CODE_PARITY_EN
         exp[35:32] = {4{vecs[i].exp_par}};
`endif
         check("table_stream", got, exp);
         check("table_model", got, model(vecs[i].data));
      end

      // Reset after 10 handshakes abandons the word with no done.
      in_valid = 1'b1; in_data = 8'h3C; tx_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      check("mid_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_tx_valid", 64'(tx_valid), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      step();
      check("mid_rel_done", 64'(done), 64'(0));
      check("mid_rel_in_ready", 64'(in_ready), 64'(1));
      do_word(8'hFF, 0, got);
      check("after_rst_stream", got, model(8'hFF));

      // in_valid held with 0x00 during 0xFF; 0x00 taken in the done cycle.
      in_valid = 1'b1; in_data = 8'hFF; tx_ready = 1'b1;
      step();
      in_data = 8'h00;
      got = '0; hs_cnt = 0; cyc = 0; bad_rdy = 0;
      while (hs_cnt < NSYM && cyc < 200) begin
         if (in_ready) bad_rdy++;
         if (tx_valid) begin
            got[hs_cnt] = tx_bit;
            hs_cnt++;
         end
         step();
         cyc++;
      end
      check("ign_stream", got, model(8'hFF));
      check("ign_in_ready_low", 64'(bad_rdy), 64'(0));
      check("b2b_done", 64'(done), 64'(1));
      check("b2b_bubble", 64'(tx_valid), 64'(0));
      check("b2b_in_ready", 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      check("b2b_second_start", 64'(tx_valid), 64'(1));
      got = '0; hs_cnt = 0; cyc = 0;
      while (hs_cnt < NSYM && cyc < 200) begin
         if (tx_valid) begin
            got[hs_cnt] = tx_bit;
            hs_cnt++;
         end
         step();
         cyc++;
      end
      check("b2b_second_stream", got, model(8'h00));
      check("b2b_second_done", 64'(done), 64'(1));
      step();

      // Random words under random backpressure
      for (int i = 0; i < 20; i++) begin
         w = DW'($urandom);
         do_word(w, 2, got);
         check("rand_stream", got, model(w));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
